// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Raster timing source for 640x480@60 Hz. Free-running horizontal and
//   vertical counters with registered sync, blanking and frame markers.
//
// Ports
//   vga_clk      in   1   pixel clock (25 MHz nominal), rising-edge active
//   reset_n      in   1   asynchronous active-low reset
//   DrawX        out  10  horizontal pixel count, 0..H_TOTAL-1
//   DrawY        out  10  line count, 0..V_TOTAL-1
//   blank        out  1   1 = visible pixel, 0 = blanking interval
//   hs           out  1   horizontal sync, active-low
//   vs           out  1   vertical sync, active-low
//   line_start   out  1   high while DrawX == 0
//   frame_start  out  1   high while DrawX == 0 and DrawY == 0
//   frame_count  out  16  completed-frame counter, wraps silently
//
// FRAME_COUNT_INIT sets the reset value of frame_count. Leave it at 0 in
// the product. It exists so a bench can reach the 16-bit wrap quickly.

module vga_timing_gen #(
    parameter int unsigned H_VISIBLE        = 640,
    parameter int unsigned H_FRONT          = 16,
    parameter int unsigned H_SYNC           = 96,
    parameter int unsigned H_BACK           = 48,
    parameter int unsigned V_VISIBLE        = 480,
    parameter int unsigned V_FRONT          = 10,
    parameter int unsigned V_SYNC           = 2,
    parameter int unsigned V_BACK           = 33,
    parameter logic [15:0] FRAME_COUNT_INIT = '0
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic        x_wrap;
    logic        y_wrap;
    logic [9:0]  x_next;
    logic [9:0]  y_next;
    logic [15:0] fc_next;
    logic        blank_next;
    logic        hs_next;
    logic        vs_next;
    logic        ls_next;
    logic        fs_next;

    // Every decoded output is computed from the next counter values and
    // registered alongside them. As a result, all outputs describe the same
    // pixel in the same cycle, with no extra pipeline stage.
    always_comb begin
        x_wrap  = (DrawX == H_LAST);
        y_wrap  = (DrawY == V_LAST);
        x_next  = x_wrap ? '0 : DrawX + 10'd1;
        y_next  = DrawY;
        fc_next = frame_count;
        if (x_wrap) begin
            y_next = y_wrap ? '0 : DrawY + 10'd1;
            if (y_wrap) begin
                fc_next = frame_count + 16'd1;
            end
        end
        blank_next = (x_next < H_VIS) && (y_next < V_VIS);
        hs_next    = !((x_next >= HS_FIRST) && (x_next <= HS_LAST));
        vs_next    = !((y_next >= VS_FIRST) && (y_next <= VS_LAST));
        ls_next    = (x_next == '0);
        fs_next    = (x_next == '0) && (y_next == '0);
    end

    // Reset asserts asynchronously and clears every flop together. Release
    // is sampled by these same flops on a rising edge, so the first
    // post-reset update moves the raster from (0,0) to (1,0).
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            DrawX       <= '0;
            DrawY       <= '0;
            blank       <= 1'b0;
            hs          <= 1'b1;
            vs          <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= FRAME_COUNT_INIT;
        end else begin
            DrawX       <= x_next;
            DrawY       <= y_next;
            blank       <= blank_next;
            hs          <= hs_next;
            vs          <= vs_next;
            line_start  <= ls_next;
            frame_start <= fs_next;
            frame_count <= fc_next;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen. It runs two instances:
//   a : full 640x480 timing (line-level behaviour, hs window, async reset)
//   b : shrunken 16x6 raster (25x11 total) with frame_count preset to
//       0xFFFE, covering full frames, vs, blank totals and the 16-bit wrap.
module tb_vga_timing_gen;

    logic        vga_clk = 1'b0;
    logic        reset_n_a;
    logic        reset_n_b;
    logic [9:0]  DrawX_a, DrawY_a, DrawX_b, DrawY_b;
    logic        blank_a, hs_a, vs_a, line_start_a, frame_start_a;
    logic        blank_b, hs_b, vs_b, line_start_b, frame_start_b;
    logic [15:0] frame_count_a, frame_count_b;

    always #5 vga_clk = ~vga_clk;

    vga_timing_gen u_dut_a (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n_a),
        .DrawX       (DrawX_a),
        .DrawY       (DrawY_a),
        .blank       (blank_a),
        .hs          (hs_a),
        .vs          (vs_a),
        .line_start  (line_start_a),
        .frame_start (frame_start_a),
        .frame_count (frame_count_a)
    );

    vga_timing_gen #(
        .H_VISIBLE        (16),
        .H_FRONT          (2),
        .H_SYNC           (4),
        .H_BACK           (3),
        .V_VISIBLE        (6),
        .V_FRONT          (1),
        .V_SYNC           (2),
        .V_BACK           (2),
        .FRAME_COUNT_INIT (16'hFFFE)
    ) u_dut_b (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n_b),
        .DrawX       (DrawX_b),
        .DrawY       (DrawY_b),
        .blank       (blank_b),
        .hs          (hs_b),
        .vs          (vs_b),
        .line_start  (line_start_b),
        .frame_start (frame_start_b),
        .frame_count (frame_count_b)
    );

    logic [40:0] obs_a, obs_b;
    assign obs_a = {DrawX_a, DrawY_a, blank_a, hs_a, vs_a, line_start_a, frame_start_a, frame_count_a};
    assign obs_b = {DrawX_b, DrawY_b, blank_b, hs_b, vs_b, line_start_b, frame_start_b, frame_count_b};

    int checks = 0;
    int errors = 0;

    logic [40:0] q_a[$];
    logic [40:0] q_b[$];

    // Reference raster positions
    int ax, ay, afc;
    int bx, by, bfc;
    bit arst, brst;

    // Tallies
    int cyc = 0;
    int ls_a_cnt, hs_low_a_cnt;
    int blank_b_cnt, vs_low_b_cnt, hs_low_b_cnt, fs_b_cnt;
    int last_fs_b = -1;

    function automatic logic [40:0] expect_vec(input int x, input int y, input int fc, input bit rst,
                                               input int hv, input int hf, input int hsw,
                                               input int vv, input int vf, input int vsw);
        logic b, h, v, l, f;
        if (rst) return {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'(fc)};
        b = (x < hv) && (y < vv);
        h = !((x >= hv + hf) && (x < hv + hf + hsw));
        v = !((y >= vv + vf) && (y < vv + vf + vsw));
        l = (x == 0);
        f = (x == 0) && (y == 0);
        return {10'(x), 10'(y), b, h, v, l, f, 16'(fc)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        logic [40:0] ea, eb;
        for (int i = 0; i < n; i++) begin
            if (arst) begin
                ax = 0; ay = 0; afc = 0;
            end else begin
                ax++;
                if (ax == 800) begin
                    ax = 0; ay++;
                    if (ay == 525) begin ay = 0; afc = (afc + 1) % 65536; end
                end
            end
            if (brst) begin
                bx = 0; by = 0; bfc = 16'hFFFE;
            end else begin
                bx++;
                if (bx == 25) begin
                    bx = 0; by++;
                    if (by == 11) begin by = 0; bfc = (bfc + 1) % 65536; end
                end
            end
            q_a.push_back(expect_vec(ax, ay, afc, arst, 640, 16, 96, 480, 10, 2));
            q_b.push_back(expect_vec(bx, by, bfc, brst, 16, 2, 4, 6, 1, 2));

            @(posedge vga_clk);
            #1;
            cyc++;
            ea = q_a.pop_front();
            eb = q_b.pop_front();
            check("raster_a", 64'(obs_a), 64'(ea));
            check("raster_b", 64'(obs_b), 64'(eb));
            check("range_a", 64'((DrawX_a < 10'd800) && (DrawY_a < 10'd525)), 64'd1);
            check("range_b", 64'((DrawX_b < 10'd25) && (DrawY_b < 10'd11)), 64'd1);

            ls_a_cnt     += int'(line_start_a);
            hs_low_a_cnt += int'(!hs_a);
            blank_b_cnt  += int'(blank_b);
            vs_low_b_cnt += int'(!vs_b);
            hs_low_b_cnt += int'(!hs_b);
            fs_b_cnt     += int'(frame_start_b);
            if (frame_start_b) begin
                if (last_fs_b >= 0) check("fs_period_b", 64'(cyc - last_fs_b), 64'd275);
                last_fs_b = cyc;
            end
        end
    endtask

    initial begin
        reset_n_a = 1'b0;
        reset_n_b = 1'b0;
        arst = 1'b1; brst = 1'b1;
        ax = 0; ay = 0; afc = 0;
        bx = 0; by = 0; bfc = 16'hFFFE;

        step(3);
        check("rst_x_a",  64'(DrawX_a), 64'd0);
        check("rst_hs_a", 64'(hs_a), 64'd1);
        check("rst_fc_a", 64'(frame_count_a), 64'd0);
        check("rst_fc_b", 64'(frame_count_b), 64'hFFFE);

        // Small raster: full frames and frame_count wrap
        @(negedge vga_clk);
        reset_n_b = 1'b1; brst = 1'b0;
        blank_b_cnt = 0; vs_low_b_cnt = 0; hs_low_b_cnt = 0; fs_b_cnt = 0;
        step(1);
        check("first_x_b",     64'(DrawX_b), 64'd1);
        check("first_y_b",     64'(DrawY_b), 64'd0);
        check("first_blank_b", 64'(blank_b), 64'd1);
        step(274);
        check("fs_first_b",    64'(frame_start_b), 64'd1);
        check("fs_count_b",    64'(fs_b_cnt), 64'd1);
        check("fc_first_b",    64'(frame_count_b), 64'hFFFF);
        check("blank_total_b", 64'(blank_b_cnt), 64'd96);
        check("vs_low_b",      64'(vs_low_b_cnt), 64'd50);
        check("hs_low_b",      64'(hs_low_b_cnt), 64'd44);
        step(275);
        check("fc_wrap_b",     64'(frame_count_b), 64'd0);
        check("fs_wrap_b",     64'(frame_start_b), 64'd1);
        check("pos_wrap_b",    64'({DrawX_b, DrawY_b}), 64'd0);
        step(275);
        check("fc_after_b",    64'(frame_count_b), 64'd1);

        // Full raster: one line, hs window, async reset mid-line
        @(negedge vga_clk);
        reset_n_a = 1'b1; arst = 1'b0;
        ls_a_cnt = 0;
        step(1);
        check("first_x_a",     64'(DrawX_a), 64'd1);
        check("first_y_a",     64'(DrawY_a), 64'd0);
        check("first_blank_a", 64'(blank_a), 64'd1);
        check("first_ls_a",    64'(line_start_a), 64'd0);
        step(799);
        check("wrap_x_a",  64'(DrawX_a), 64'd0);
        check("wrap_y_a",  64'(DrawY_a), 64'd1);
        check("wrap_ls_a", 64'(line_start_a), 64'd1);
        check("ls_cnt1_a", 64'(ls_a_cnt), 64'd1);
        ls_a_cnt = 0; hs_low_a_cnt = 0;
        step(800);
        check("ls_cnt2_a",   64'(ls_a_cnt), 64'd1);
        check("hs_low_a",    64'(hs_low_a_cnt), 64'd96);
        step(655);
        check("x655_a",  64'(DrawX_a), 64'd655);
        check("hs655_a", 64'(hs_a), 64'd1);
        step(1);
        check("hs656_a", 64'(hs_a), 64'd0);
        step(95);
        check("x751_a",  64'(DrawX_a), 64'd751);
        check("hs751_a", 64'(hs_a), 64'd0);
        step(1);
        check("hs752_a", 64'(hs_a), 64'd1);
        step(348);
        check("x300_a", 64'({DrawX_a, DrawY_a}), 64'({10'd300, 10'd3}));

        @(negedge vga_clk);
        reset_n_a = 1'b0; arst = 1'b1;
        ax = 0; ay = 0; afc = 0;
        #1;
        check("async_rst_a", 64'(obs_a), 64'(expect_vec(0, 0, 0, 1'b1, 640, 16, 96, 480, 10, 2)));
        step(2);
        @(negedge vga_clk);
        reset_n_a = 1'b1; arst = 1'b0;
        step(1);
        check("restart_x_a",     64'(DrawX_a), 64'd1);
        check("restart_blank_a", 64'(blank_a), 64'd1);
        step(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
